fetch_unit: RTL

- Front-end stage directly upstream of the instruction queue.
- Owns the architectural fetch PC and issues one instruction-memory read at a time.
- Pushes each returned instruction, with its PC and sequential next-PC, into the queue when the queue has space.
- On a redirect (branch flush, jump, or taken prediction) it retargets the PC and discards any in-flight or held instruction, in step with the queue's own flush.

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 106 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, instruction-queue push port
// and the redirect input from the back end.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] imem_addr;
  logic [3:0]      imem_rmask;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_resp;
  logic [XLEN-1:0] iq_wdata;
  logic [XLEN-1:0] iq_pc;
  logic [XLEN-1:0] iq_pc_next;
  logic            iq_enqueue;
  logic            iq_full;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  // Fetch unit side
  modport master (
    output imem_addr, imem_rmask, iq_wdata, iq_pc, iq_pc_next, iq_enqueue,
    input  imem_rdata, imem_resp, iq_full, redirect_valid, redirect_pc
  );

  // Memory / queue / back-end side
  modport slave (
    input  imem_addr, imem_rmask, iq_wdata, iq_pc, iq_pc_next, iq_enqueue,
    output imem_rdata, imem_resp, iq_full, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps one imem read in
// flight, pushes returned words into the instruction queue, and retargets
// on redirect while throwing away any in-flight or held instruction.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h1eceb000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] STALL   = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] hold_reg, hold_next;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_target;
  logic            req;
  logic            enq;
  logic [XLEN-1:0] enq_data;

  assign pc_plus4        = pc_reg + {{(XLEN-3){1'b0}}, 3'd4};
  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // Next-state, request and enqueue decode; a redirect always beats an enqueue
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    hold_next  = hold_reg;
    req        = 1'b0;
    enq        = 1'b0;
    enq_data   = '0;
    case (state_reg)
      FETCH: begin
        if (bus.redirect_valid) begin
          pc_next = redirect_target;
        end else begin
          req        = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          pc_next    = redirect_target;
          state_next = bus.imem_resp ? FETCH : DISCARD;
        end else if (bus.imem_resp) begin
          if (!bus.iq_full) begin
            enq        = 1'b1;
            enq_data   = bus.imem_rdata;
            pc_next    = pc_plus4;
            state_next = FETCH;
          end else begin
            hold_next  = bus.imem_rdata;
            state_next = STALL;
          end
        end
      end
      STALL: begin
        if (bus.redirect_valid) begin
          pc_next    = redirect_target;
          state_next = FETCH;
        end else if (!bus.iq_full) begin
          enq        = 1'b1;
          enq_data   = hold_reg;
          pc_next    = pc_plus4;
          state_next = FETCH;
        end
      end
      default: begin // DISCARD: wait out the stale response, tracking the newest redirect
        if (bus.redirect_valid) pc_next = redirect_target;
        if (bus.imem_resp) state_next = FETCH;
      end
    endcase
    // Outputs must read idle the moment reset asserts, not at the next edge
    if (!rst) begin
      req = 1'b0;
      enq = 1'b0;
    end
  end

  // State, PC and hold register update with asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      hold_reg  <= hold_next;
    end
  end

  assign bus.imem_addr  = {pc_reg[XLEN-1:2], 2'b00};
  assign bus.imem_rmask = req ? 4'hF : 4'h0;
  assign bus.iq_enqueue = enq;
  assign bus.iq_wdata   = enq ? enq_data : '0;
  assign bus.iq_pc      = enq ? pc_reg   : '0;
  assign bus.iq_pc_next = enq ? pc_plus4 : '0;

endmodule
